asp_host_mem_wr_arb: RTL



---
 rtl/asp_host_mem_wr_arb.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/asp_host_mem_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : asp_host_mem_wr_arb
//  Description : Host-memory write-channel arbiter. Forwards ASP DMA write
//                bursts to the PIM write sink, injects single-beat interrupt
//                writes (round-robin, maskable) at burst boundaries, and
//                sequences write-fence + magic-number beat pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module asp_host_mem_wr_arb #(
  parameter int NUM_IRQ     = 4,
  parameter int IRQ_EN      = 1,
  parameter int ADDR_W      = 48,
  parameter int DATA_W      = 512,
  parameter int BURST_W     = 7,
  parameter int USER_W      = 8,
  parameter int UFLAG_IRQ   = 0,
  parameter int UFLAG_FENCE = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_IRQ-1:0]    asp_irq,
  input  logic [NUM_IRQ-1:0]    irq_mask,
  input  logic                  wr_fence_flag,
  input  logic                  src_wr_write,
  input  logic [ADDR_W-1:0]     src_wr_address,
  input  logic [BURST_W-1:0]    src_wr_burstcount,
  input  logic [DATA_W-1:0]     src_wr_writedata,
  input  logic [DATA_W/8-1:0]   src_wr_byteenable,
  output logic                  src_wr_waitrequest,
  output logic                  host_wr_write,
  output logic [ADDR_W-1:0]     host_wr_address,
  output logic [BURST_W-1:0]    host_wr_burstcount,
  output logic [DATA_W-1:0]     host_wr_writedata,
  output logic [DATA_W/8-1:0]   host_wr_byteenable,
  output logic [USER_W-1:0]     host_wr_user,
  input  logic                  host_wr_waitrequest,
  output logic [NUM_IRQ-1:0]    irq_pending,
  output logic                  irq_dropped
);

  localparam int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int PTR_W    = IRQ_ID_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IRQ   = 3'd1;
  localparam logic [2:0] S_FENCE = 3'd2;
  localparam logic [2:0] S_MAGIC = 3'd3;
  localparam logic [2:0] S_BURST = 3'd4;

  // FSM and burst tracking
  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [BURST_W-1:0]  r_rem;
  logic [BURST_W-1:0]  w_rem_nxt;
  logic [IRQ_ID_W-1:0] r_irq_id;

  // Interrupt bookkeeping
  logic [NUM_IRQ-1:0]  r_pending;
  logic [NUM_IRQ-1:0]  r_irq_d;
  logic                r_dropped;
  logic [IRQ_ID_W-1:0] r_rr_ptr;
  logic [NUM_IRQ-1:0]  w_set;
  logic [NUM_IRQ-1:0]  w_clr;
  logic [NUM_IRQ-1:0]  w_elig;
  logic                w_found;
  logic [IRQ_ID_W-1:0] w_sel_id;
  logic [PTR_W-1:0]    w_rr_idx;
  logic [IRQ_ID_W-1:0] w_rr_nxt;

  // Beat presented to the sink before reset gating
  logic                w_write;
  logic                w_src_wait;
  logic [ADDR_W-1:0]   w_addr;
  logic [BURST_W-1:0]  w_bcnt;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_be;
  logic [USER_W-1:0]   w_user;
  logic                w_acc;
  logic                w_irq_acc;

  assign w_acc     = w_write & ~host_wr_waitrequest;
  assign w_irq_acc = (r_state == S_IRQ) & w_acc;
  assign w_set     = asp_irq & ~r_irq_d;
  assign w_elig    = r_pending & ~irq_mask;
  assign w_rr_nxt  = (r_irq_id == IRQ_ID_W'(NUM_IRQ - 1)) ? '0 : r_irq_id + IRQ_ID_W'(1);

  // Round-robin pick: first eligible line at or above the pointer, wrapping
  always_comb begin
    w_found  = 1'b0;
    w_sel_id = '0;
    w_rr_idx = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      w_rr_idx = {1'b0, r_rr_ptr} + PTR_W'(k);
      if (w_rr_idx >= PTR_W'(NUM_IRQ)) begin
        w_rr_idx = w_rr_idx - PTR_W'(NUM_IRQ);
      end
      if (!w_found && w_elig[w_rr_idx[IRQ_ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_sel_id = w_rr_idx[IRQ_ID_W-1:0];
      end
    end
  end

  // One-hot clear of the line whose interrupt beat is being accepted
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = w_irq_acc && (r_irq_id == IRQ_ID_W'(i));
    end
  end

  // Pending flags, edge detect, drop pulse and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_d   <= '0;
      r_pending <= '0;
      r_dropped <= 1'b0;
      r_rr_ptr  <= '0;
    end else if (IRQ_EN == 0) begin
      r_irq_d   <= '0;
      r_pending <= '0;
      r_dropped <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      r_irq_d   <= asp_irq;
      // A new edge wins over a same-cycle clear so no request is lost
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_dropped <= |(w_set & r_pending);
      if (w_irq_acc) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  // State register, remaining-beat counter and latched interrupt id
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_irq_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if ((r_state == S_IDLE) && w_found) begin
        r_irq_id <= w_sel_id;
      end
    end
  end

  // Next-state: IDLE decisions not accepted this cycle move into a holding state
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_IRQ;
        end else if (src_wr_write && wr_fence_flag) begin
          w_state_nxt = w_acc ? S_MAGIC : S_FENCE;
        end else if (src_wr_write) begin
          if (!w_acc) begin
            w_state_nxt = S_BURST;
            w_rem_nxt   = src_wr_burstcount;
          end else if (src_wr_burstcount != BURST_W'(1)) begin
            w_state_nxt = S_BURST;
            w_rem_nxt   = src_wr_burstcount - BURST_W'(1);
          end
        end
      end
      S_IRQ: begin
        if (w_acc) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FENCE: begin
        if (w_acc) begin
          w_state_nxt = S_MAGIC;
        end
      end
      S_MAGIC: begin
        if (w_acc) begin
          if (src_wr_burstcount == BURST_W'(1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BURST;
            w_rem_nxt   = src_wr_burstcount - BURST_W'(1);
          end
        end
      end
      S_BURST: begin
        if (w_acc) begin
          w_rem_nxt = r_rem - BURST_W'(1);
          if (r_rem == BURST_W'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = '0;
      end
    endcase
  end

  // Output decode: source fields by default, overridden for IRQ and fence beats
  always_comb begin
    w_write    = src_wr_write;
    w_src_wait = host_wr_waitrequest;
    w_addr     = src_wr_address;
    w_bcnt     = src_wr_burstcount;
    w_data     = src_wr_writedata;
    w_be       = src_wr_byteenable;
    w_user     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_write    = 1'b0;
          w_src_wait = 1'b1;
        end else if (src_wr_write && wr_fence_flag) begin
          // Fence copy of the beat; the source keeps it for the magic write
          w_user[UFLAG_FENCE] = 1'b1;
          w_src_wait          = 1'b1;
        end
      end
      S_IRQ: begin
        w_write           = 1'b1;
        w_src_wait        = 1'b1;
        w_addr            = ADDR_W'(r_irq_id);
        w_bcnt            = BURST_W'(1);
        w_data            = '0;
        w_be              = '1;
        w_user[UFLAG_IRQ] = 1'b1;
      end
      S_FENCE: begin
        w_write             = 1'b1;
        w_src_wait          = 1'b1;
        w_user[UFLAG_FENCE] = 1'b1;
      end
      S_MAGIC, S_BURST: begin
        w_write = src_wr_write;
      end
      default: begin
        w_write    = 1'b0;
        w_src_wait = 1'b1;
      end
    endcase
  end

  // Reset also forces the sink idle and the source stalled
  assign host_wr_write      = w_write & reset_n;
  assign src_wr_waitrequest = w_src_wait | ~reset_n;
  assign host_wr_user       = reset_n ? w_user : '0;
  assign host_wr_address    = w_addr;
  assign host_wr_burstcount = w_bcnt;
  assign host_wr_writedata  = w_data;
  assign host_wr_byteenable = w_be;
  assign irq_pending        = r_pending;
  assign irq_dropped        = r_dropped;

  // A start-of-burst beat must never carry a zero burst count
  a_no_zero_burst: assert property (@(posedge clk) disable iff (!reset_n)
    (src_wr_write && ((r_state == S_IDLE) || (r_state == S_MAGIC))) |-> (src_wr_burstcount != '0));

endmodule
`default_nettype wire
